des_key_sched: RTL and testbench

//   Iterative DES subkey generator for the spi_des datapath; the key-side counterpart of the S-box round logic.

---
 rtl/des_pkg.sv | 64 ++++++
 rtl/des_pc2.sv | 17 +
 rtl/des_key_sched.sv | 112 +++++++++++
 tb/tb_des_key_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, tables and helpers.
// Bit 1 is the MSB of every vector (FIPS 46-3 numbering).
package des_pkg;

  localparam int unsigned DES_KEY_W    = 64;
  localparam int unsigned DES_CD_W     = 56;
  localparam int unsigned DES_HALF_W   = 28;
  localparam int unsigned DES_SUBKEY_W = 48;
  localparam int unsigned DES_IDX_W    = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [DES_HALF_W-1:0] c;
    logic [DES_HALF_W-1:0] d;
  } des_cd_t;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry n-1 holds the rotate amount for key number n.
  localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [DES_CD_W-1:0] pc1_perm(input logic [DES_KEY_W-1:0] key);
    logic [DES_CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return cd;
  endfunction

  function automatic logic [DES_HALF_W-1:0] rotl28(input logic [DES_HALF_W-1:0] x,
                                                   input int unsigned amt);
    return (amt == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [DES_HALF_W-1:0] rotr28(input logic [DES_HALF_W-1:0] x,
                                                   input int unsigned amt);
    return (amt == 1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 permutation: 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [DES_CD_W-1:0]     cd,
  output logic [DES_SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < int'(DES_SUBKEY_W); i++) begin : g_bit
    assign subkey[6'(DES_SUBKEY_W - 1 - i)] = cd[6'(DES_CD_W - PC2[i])];
  end

  // CD bits 9,18,22,25,35,38,43,54 are discarded by PC-2.
  logic unused_dropped;
  assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES subkey generator: one 48-bit subkey per valid/ready handshake,
// ascending K1..K16 for encryption or descending K16..K1 via right rotations.
module des_key_sched
  import des_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DES_KEY_W-1:0]    key_in,
  input  logic                    key_load,
  input  logic                    decrypt,
  output logic [DES_SUBKEY_W-1:0] subkey,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic [3:0]              round_idx,
  output logic                    busy,
  output logic                    done
);

  logic [1:0]           state_q, state_d;
  des_cd_t              cd_q, cd_d, cd0;
  logic                 mode_q, mode_d;
  logic [DES_IDX_W-1:0] idx_q, idx_d;
  logic                 valid_d, busy_d, done_d;
  logic                 last_c;

  assign cd0    = pc1_perm(key_in);
  assign last_c = mode_q ? (idx_q == 5'd1) : (idx_q == 5'd16);

  // Key number 16 reads as 0 on the 4-bit port; subkey_valid tells it apart from idle.
  assign round_idx = idx_q[3:0];

  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cd_q         <= '0;
      mode_q       <= 1'b0;
      idx_q        <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      subkey_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    valid_d = subkey_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          state_d = ST_RUN;
          mode_d  = decrypt;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          // Total rotation over 16 rounds is 28, so C0,D0 already equals C16,D16.
          if (decrypt) begin
            cd_d  = cd0;
            idx_d = 5'd16;
          end else begin
            cd_d.c = rotl28(cd0.c, 1);
            cd_d.d = rotl28(cd0.d, 1);
            idx_d  = 5'd1;
          end
        end
      end
      ST_RUN: begin
        if (subkey_valid && subkey_ready) begin
          if (last_c) begin
            state_d = ST_DONE;
            cd_d    = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (mode_q) begin
            cd_d.c = rotr28(cd_q.c, SHIFT[4'(idx_q - 5'd1)]);
            cd_d.d = rotr28(cd_q.d, SHIFT[4'(idx_q - 5'd1)]);
            idx_d  = idx_q - 5'd1;
          end else begin
            cd_d.c = rotl28(cd_q.c, SHIFT[idx_q[3:0]]);
            cd_d.d = rotl28(cd_q.d, SHIFT[idx_q[3:0]]);
            idx_d  = idx_q + 5'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: vector table of key runs, a reference
// subkey model feeding a scoreboard, plus stall, reload, reset and DONE-cycle sequences.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        decrypt;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .decrypt      (decrypt),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int unsigned ready_pct;
    bit          poke;
    int          rst_after;
    bit          has_const;
    logic [47:0] first_sk;
    logic [47:0] last_sk;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam int unsigned T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int unsigned T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Key n computed from C0,D0 by the cumulative left shift, independent of direction.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int unsigned total;
    cd = '0;
    r  = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - T_PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    total = 0;
    for (int j = 0; j < n; j++) total += T_SH[j];
    for (int j = 0; j < int'(total); j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - T_PC2[i])];
    return r;
  endfunction

  task automatic run_vec(input int vi, input vec_t v);
    int          acc;
    int          cyc;
    bit          stalled;
    logic [47:0] held_sk;
    logic [3:0]  held_idx;
    exp_t        e;
    string       tag;
    tag = $sformatf("v%0d", vi);
    sb.delete();
    @(posedge clk); #1;
    key_in       = v.key;
    decrypt      = v.dec;
    key_load     = 1'b1;
    subkey_ready = 1'b0;
    if (v.dec) begin
      for (int n = 16; n >= 1; n--) sb.push_back(exp_t'{model_key(v.key, n), 4'(n)});
    end else begin
      for (int n = 1; n <= 16; n++) sb.push_back(exp_t'{model_key(v.key, n), 4'(n)});
    end
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in   = ~v.key;
    decrypt  = ~v.dec;
    acc      = 0;
    cyc      = 0;
    stalled  = 1'b0;
    held_sk  = '0;
    held_idx = '0;
    while (acc < 16 && cyc < 4000) begin
      if (v.rst_after == acc) begin
        rst          = 1'b1;
        subkey_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_rst_valid"}, 64'(subkey_valid), 64'(0));
        check({tag, "_rst_busy"},  64'(busy),         64'(0));
        check({tag, "_rst_idx"},   64'(round_idx),    64'(0));
        check({tag, "_rst_done"},  64'(done),         64'(0));
        check({tag, "_rst_sk"},    64'(subkey),       64'(0));
        repeat (3) begin
          @(negedge clk);
          check({tag, "_post_rst_done"},  64'(done),         64'(0));
          check({tag, "_post_rst_valid"}, 64'(subkey_valid), 64'(0));
        end
        sb.delete();
        return;
      end
      subkey_ready = ($urandom_range(99) < v.ready_pct);
      key_load     = v.poke && (acc == 4 || acc == 15);
      key_in       = {$urandom, $urandom};
      @(negedge clk);
      check({tag, "_valid"}, 64'(subkey_valid), 64'(1));
      check({tag, "_busy"},  64'(busy),         64'(1));
      check({tag, "_done"},  64'(done),         64'(0));
      if (stalled) begin
        check({tag, "_hold_sk"},  64'(subkey),    64'(held_sk));
        check({tag, "_hold_idx"}, 64'(round_idx), 64'(held_idx));
      end
      stalled  = !subkey_ready;
      held_sk  = subkey;
      held_idx = round_idx;
      if (subkey_ready) begin
        if (sb.size() == 0) begin
          check({tag, "_sb_underflow"}, 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check($sformatf("%s_sk%0d", tag, acc),  64'(subkey),    64'(e.sk));
          check($sformatf("%s_idx%0d", tag, acc), 64'(round_idx), 64'(e.idx));
        end
        if (v.has_const && acc == 0)  check({tag, "_first"}, 64'(subkey), 64'(v.first_sk));
        if (v.has_const && acc == 15) check({tag, "_last"},  64'(subkey), 64'(v.last_sk));
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    subkey_ready = 1'b0;
    key_load     = 1'b0;
    if (acc < 16) begin
      check({tag, "_timeout_accepts"}, 64'(acc), 64'(16));
      return;
    end
    // DONE cycle: a key_load here must be ignored.
    key_load = 1'b1;
    key_in   = v.key ^ 64'h0F0F_0F0F_0F0F_0F0F;
    decrypt  = v.dec;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done),         64'(1));
    check({tag, "_end_valid"},  64'(subkey_valid), 64'(0));
    check({tag, "_end_busy"},   64'(busy),         64'(0));
    check({tag, "_end_idx"},    64'(round_idx),    64'(0));
    check({tag, "_end_sk"},     64'(subkey),       64'(0));
    @(posedge clk); #1;
    key_load = 1'b0;
    @(negedge clk);
    check({tag, "_done_1cyc"},    64'(done),         64'(0));
    check({tag, "_done_ld_ign"},  64'(subkey_valid), 64'(0));
    check({tag, "_done_ld_busy"}, 64'(busy),         64'(0));
    check({tag, "_sb_empty"},     64'(sb.size()),    64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [63:0] rk;
    rk = {$urandom, $urandom};
    //          key                    dec  rdy poke rst  const first               last
    vecs[0]  = '{64'h133457799BBCDFF1, 1'b0, 100, 1'b0, -1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[1]  = '{64'h133457799BBCDFF1, 1'b1, 100, 1'b0, -1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2]  = '{64'h133457799BBCDFF1, 1'b0,  30, 1'b0, -1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[3]  = '{64'h133457799BBCDFF1, 1'b1,  30, 1'b0, -1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[4]  = '{64'h133457799BBCDFF1, 1'b0, 100, 1'b1, -1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[5]  = '{64'h133457799BBCDFF1, 1'b0, 100, 1'b0,  8, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[6]  = '{64'h133457799BBCDFF1, 1'b0, 100, 1'b0, -1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[7]  = '{64'h0000000000000000, 1'b0,  70, 1'b0, -1, 1'b1, 48'h000000000000, 48'h000000000000};
    vecs[8]  = '{64'h0000000000000000, 1'b1,  70, 1'b0, -1, 1'b1, 48'h000000000000, 48'h000000000000};
    vecs[9]  = '{64'hFFFFFFFFFFFFFFFF, 1'b0,  70, 1'b0, -1, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    vecs[10] = '{64'hFFFFFFFFFFFFFFFF, 1'b1,  70, 1'b0, -1, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    vecs[11] = '{rk,                   1'b1,  50, 1'b1, -1, 1'b0, 48'h0,            48'h0};

    rst          = 1'b1;
    key_in       = '0;
    key_load     = 1'b0;
    decrypt      = 1'b0;
    subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(subkey_valid), 64'(0));
    check("reset_idx",   64'(round_idx),    64'(0));
    check("reset_busy",  64'(busy),         64'(0));
    check("reset_done",  64'(done),         64'(0));
    check("reset_sk",    64'(subkey),       64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Ready with nothing valid must not start anything.
    subkey_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_ready_valid", 64'(subkey_valid), 64'(0));
    check("idle_ready_busy",  64'(busy),         64'(0));
    subkey_ready = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
